io_input_cond: RTL



---
 rtl/io_cond_pkg.sv | 15 +
 rtl/debounce_bit.sv | 53 +++++
 rtl/io_input_cond.sv | 93 +++++++++
 3 files changed

// File: rtl/io_cond_pkg.sv
// Shared constants and sizing helper for the DE-board switch/button conditioning stage.
package io_cond_pkg;

    localparam int TICK_DIV_DEF    = 50000;
    localparam int DEB_TICKS_DEF   = 5;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [3:0] BTN_IDLE_DEF = 4'hF;

    // Bits needed to hold 0..max_val; never narrower than one bit so a
    // degenerate divider still gets a real register.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw input bit: synchroniser chain, tick-driven debounce counter and clean output flop.
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   DEB_TICKS   = DEB_TICKS_DEF,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic out_o,
    output logic flip_o
);

    localparam int CNT_W = cnt_width(DEB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   out_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    // flip_o is high on exactly the edge that will load the new level into out_r
    assign flip_o = (sync_s != out_r) & tick_i & (cnt_r == CNT_LAST);
    assign out_o  = out_r;

    // Synchroniser shift, debounce counter and clean output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
            cnt_r  <= {CNT_W{1'b0}};
            out_r  <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_i};
            if (sync_s == out_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (tick_i) begin
                if (cnt_r == CNT_LAST) begin
                    out_r <= sync_s;
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/io_input_cond.sv
// Synchronises and debounces raw DE-board switches/keys for the LSU and emits
// one-cycle press/release pulses for the buttons.
module io_input_cond
    import io_cond_pkg::*;
#(
    parameter int SW_W        = 32,
    parameter int BTN_W       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int DEB_TICKS   = DEB_TICKS_DEF,
    parameter logic [BTN_W-1:0] BTN_IDLE = BTN_IDLE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SW_W-1:0]  sw_raw_i,
    input  logic [BTN_W-1:0] btn_raw_i,
    output logic [SW_W-1:0]  io_sw_o,
    output logic [BTN_W-1:0] io_btn_o,
    output logic [BTN_W-1:0] btn_press_o,
    output logic [BTN_W-1:0] btn_release_o
);

    localparam int PRE_W = cnt_width(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [SW_W-1:0]  sw_deb_s;
    logic [SW_W-1:0]  sw_flip_unused_s;
    logic [BTN_W-1:0] btn_deb_s;
    logic [BTN_W-1:0] btn_flip_s;
    logic [BTN_W-1:0] press_r;
    logic [BTN_W-1:0] release_r;

    assign tick_s = (pre_r == PRE_W'(TICK_DIV - 1));

    // Shared sample-tick prescaler
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            pre_r <= {PRE_W{1'b0}};
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_TICKS   (DEB_TICKS),
            .RST_VAL     (1'b0)
        ) u_deb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick_s),
            .raw_i  (sw_raw_i[i]),
            .out_o  (sw_deb_s[i]),
            .flip_o (sw_flip_unused_s[i])
        );
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_TICKS   (DEB_TICKS),
            .RST_VAL     (BTN_IDLE[i])
        ) u_deb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick_s),
            .raw_i  (btn_raw_i[i]),
            .out_o  (btn_deb_s[i]),
            .flip_o (btn_flip_s[i])
        );
    end

    // Pulses land on the same edge as the flip: currently idle means a press
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_r   <= {BTN_W{1'b0}};
            release_r <= {BTN_W{1'b0}};
        end else begin
            press_r   <= btn_flip_s & ~(btn_deb_s ^ BTN_IDLE);
            release_r <= btn_flip_s & (btn_deb_s ^ BTN_IDLE);
        end
    end

    assign io_sw_o       = sw_deb_s;
    assign io_btn_o      = btn_deb_s;
    assign btn_press_o   = press_r;
    assign btn_release_o = release_r;

endmodule
